// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the single-port SRAM arbiter.
// Response ownership encoding and byte-strobe to bit-enable expansion.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // Active-low bit write enables: a set strobe bit opens its whole byte lane.
  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] bweb;
    for (int i = 0; i < 4; i++) begin
      bweb[8*i +: 8] = {8{~strb[i]}};
    end
    return bweb;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Grant selection between fetch (M0) and LSU (M1): M1 has priority, but
// M0 is forced through after STARVE_MAX consecutive M1 wins while it waits.
module sram_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_valid,
  input  logic m1_valid,
  output logic gnt0,
  output logic gnt1
);
  import mem_arb_pkg::*;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  logic       force_m0;

  always_comb begin
    force_m0 = (starve_cnt_q == StarveMax);
    gnt1     = ~rst & m1_valid & ~(force_m0 & m0_valid);
    gnt0     = ~rst & m0_valid & ~gnt1;
  end

  // Count only cycles where M0 was waiting and lost; saturate at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt0 || !m0_valid) begin
      starve_cnt_d = '0;
    end else if (gnt1 && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester front end for one single-port SRAM: drives CEB/WEB/BWEB/A/DI
// from the granted request and returns data/acks one cycle after the grant.
module sram_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [3:0]        m1_wstrb,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [DATA_W-1:0] sram_bweb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);
  import mem_arb_pkg::*;

  logic   gnt0;
  logic   gnt1;
  owner_e owner_q;
  owner_e owner_d;

  sram_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .m0_valid(m0_valid),
    .m1_valid(m1_valid),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign m0_ready = gnt0;
  assign m1_ready = gnt1;

  // An all-zero strobe write is acked but never touches the array.
  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;
    if (gnt0) begin
      sram_ceb = 1'b0;
      sram_a   = m0_addr;
    end else if (gnt1) begin
      if (!m1_we) begin
        sram_ceb = 1'b0;
        sram_a   = m1_addr;
      end else if (m1_wstrb != 4'd0) begin
        sram_ceb  = 1'b0;
        sram_web  = 1'b0;
        sram_bweb = DATA_W'(strb_to_bweb(m1_wstrb));
        sram_a    = m1_addr;
        sram_di   = m1_wdata;
      end
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt0) begin
      owner_d = OWN_M0;
    end else if (gnt1) begin
      owner_d = OWN_M1;
    end
  end

  // ---- response stage: owner of last cycle's access sees sram_do ----
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Gating with rst drops a response whose access completed just as reset hit.
  assign m0_rvalid = ~rst & (owner_q == OWN_M0);
  assign m1_rvalid = ~rst & (owner_q == OWN_M1);
  assign m0_rdata  = sram_do;
  assign m1_rdata  = sram_do;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, directed scenarios and
// random traffic checked against a reference memory and grant-rule model.
module tb_sram_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_valid = 1'b0;
  logic          m0_ready;
  logic [AW-1:0] m0_addr = '0;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_valid = 1'b0;
  logic          m1_ready;
  logic          m1_we = 1'b0;
  logic [3:0]    m1_wstrb = '0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          sram_ceb;
  logic          sram_web;
  logic [DW-1:0] sram_bweb;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_di;
  logic [DW-1:0] sram_do = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:63];

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM with bit write enables and 1-cycle read.
  always @(posedge clk) begin
    logic [31:0] tmp;
    if (!sram_ceb) begin
      if (!sram_web) begin
        tmp = mem[sram_a];
        for (int i = 0; i < 32; i++) if (!sram_bweb[i]) tmp[i] = sram_di[i];
        mem[sram_a] <= tmp;
      end else begin
        sram_do <= mem[sram_a];
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    m1_we    = 1'b0;
    m1_wstrb = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m0_valid = 1'b1; m1_valid = 1'b1; m1_we = 1'b1; m1_wstrb = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || sram_ceb !== 1'b1 || sram_web !== 1'b1 ||
          sram_bweb !== 32'hFFFF_FFFF || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs rdy=%b%b ceb=%b web=%b bweb=%h rv=%b%b want rdy=00 ceb=1 web=1 bweb=ffffffff rv=00",
                 m0_ready, m1_ready, sram_ceb, sram_web, sram_bweb, m0_rvalid, m1_rvalid);
      end
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || sram_ceb !== 1'b1 || sram_a !== '0) begin
      errors++;
      $display("FAIL reset_idle rv=%b%b ceb=%b a=%0d want rv=00 ceb=1 a=0", m0_rvalid, m1_rvalid, sram_ceb, sram_a);
    end
    next_cycle();
  endtask

  task automatic test_m0_stream;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        m0_valid = 1'b1;
        m0_addr  = AW'(k);
      end else begin
        m0_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (m0_ready !== 1'b1 || sram_ceb !== 1'b0 || sram_web !== 1'b1 || sram_a !== AW'(k)) begin
          errors++;
          $display("FAIL m0_stream_issue k=%0d ready=%b ceb=%b web=%b a=%0d want ready=1 ceb=0 web=1 a=%0d",
                   k, m0_ready, sram_ceb, sram_web, sram_a, k);
        end
      end
      if (k > 0) begin
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== ref_mem[k-1]) begin
          errors++;
          $display("FAIL m0_stream_data k=%0d rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                   k, m0_rvalid, m0_rdata, ref_mem[k-1]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_partial_write;
    logic [31:0] old;
    logic [31:0] expv;
    old  = ref_mem[5];
    expv = {old[31:24], 8'hBB, old[15:8], 8'hDD};
    m1_valid = 1'b1; m1_we = 1'b1; m1_wstrb = 4'b0101; m1_addr = AW'(5); m1_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    checks++;
    if (m1_ready !== 1'b1 || sram_ceb !== 1'b0 || sram_web !== 1'b0 || sram_bweb !== 32'hFF00_FF00 ||
        sram_a !== AW'(5) || sram_di !== 32'hAABB_CCDD) begin
      errors++;
      $display("FAIL pwrite_issue ready=%b ceb=%b web=%b bweb=%h a=%0d di=%h want 1 0 0 ff00ff00 5 aabbccdd",
               m1_ready, sram_ceb, sram_web, sram_bweb, sram_a, sram_di);
    end
    next_cycle();
    m1_we = 1'b0; m1_wstrb = '0;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_ready !== 1'b1 || sram_web !== 1'b1 || sram_ceb !== 1'b0) begin
      errors++;
      $display("FAIL pwrite_ack rvalid=%b ready=%b web=%b ceb=%b want 1 1 1 0", m1_rvalid, m1_ready, sram_web, sram_ceb);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== expv) begin
      errors++;
      $display("FAIL pwrite_readback rvalid=%b rdata=%h want rvalid=1 rdata=%h", m1_rvalid, m1_rdata, expv);
    end
    ref_mem[5] = expv;
    next_cycle();
  endtask

  task automatic test_contention;
    logic exp_m1 [10];
    exp_m1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    m0_valid = 1'b1; m0_addr = AW'(10);
    m1_valid = 1'b1; m1_we = 1'b0; m1_addr = AW'(9);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (m1_ready !== exp_m1[k] || m0_ready !== ~exp_m1[k]) begin
        errors++;
        $display("FAIL contention_order k=%0d m0_ready=%b m1_ready=%b want m0_ready=%b m1_ready=%b",
                 k, m0_ready, m1_ready, ~exp_m1[k], exp_m1[k]);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_zero_strobe;
    m1_valid = 1'b1; m1_we = 1'b1; m1_wstrb = 4'b0000; m1_addr = AW'(7); m1_wdata = $urandom;
    @(negedge clk);
    checks++;
    if (m1_ready !== 1'b1 || sram_ceb !== 1'b1) begin
      errors++;
      $display("FAIL zstrb_issue ready=%b ceb=%b want ready=1 ceb=1", m1_ready, sram_ceb);
    end
    next_cycle();
    m1_we = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL zstrb_ack rvalid=%b want 1", m1_rvalid);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== ref_mem[7]) begin
      errors++;
      $display("FAIL zstrb_unchanged rvalid=%b rdata=%h want rvalid=1 rdata=%h", m1_rvalid, m1_rdata, ref_mem[7]);
    end
    next_cycle();
  endtask

  task automatic test_reset_midflight;
    logic exp_m1 [5];
    exp_m1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    m0_valid = 1'b1; m0_addr = AW'(3);
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant m0_ready=%b want 1", m0_ready);
    end
    next_cycle();
    rst = 1'b1;
    m0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_dropped m0_rvalid=%b want 0", m0_rvalid);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after rv=%b%b want 00", m0_rvalid, m1_rvalid);
    end
    next_cycle();
    // Build up starvation, then reset while both requesters keep asking.
    m0_valid = 1'b1; m0_addr = AW'(11);
    m1_valid = 1'b1; m1_we = 1'b0; m1_addr = AW'(12);
    for (int k = 0; k < 3; k++) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || sram_ceb !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_block rdy=%b%b ceb=%b want rdy=00 ceb=1", m0_ready, m1_ready, sram_ceb);
    end
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (m1_ready !== exp_m1[k] || m0_ready !== ~exp_m1[k]) begin
        errors++;
        $display("FAIL rstmid_order k=%0d m0_ready=%b m1_ready=%b want m0_ready=%b m1_ready=%b",
                 k, m0_ready, m1_ready, ~exp_m1[k], exp_m1[k]);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_random;
    int          streak = 0;
    logic        p0 = 1'b0, p1 = 1'b0, p1_rd = 1'b0;
    logic [31:0] p0_d = '0, p1_d = '0;
    logic        e0, e1, e_ceb;
    int          a;
    logic [31:0] w;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if (m0_rvalid !== p0 || (p0 && m0_rdata !== p0_d)) begin
        errors++;
        $display("FAIL rand_m0_resp cyc=%0d rvalid=%b rdata=%h want rvalid=%b rdata=%h", cyc, m0_rvalid, m0_rdata, p0, p0_d);
      end
      checks++;
      if (m1_rvalid !== p1 || (p1 && p1_rd && m1_rdata !== p1_d)) begin
        errors++;
        $display("FAIL rand_m1_resp cyc=%0d rvalid=%b rdata=%h want rvalid=%b rdata=%h", cyc, m1_rvalid, m1_rdata, p1, p1_d);
      end
      // M1 wins unless M0 has already lost STARVE_MAX times in a row.
      e1 = m1_valid && !(m0_valid && streak == SM);
      e0 = m0_valid && !e1;
      e_ceb = !(e0 || (e1 && (!m1_we || m1_wstrb != 4'd0)));
      checks++;
      if (m0_ready !== e0 || m1_ready !== e1 || sram_ceb !== e_ceb) begin
        errors++;
        $display("FAIL rand_grant cyc=%0d rdy=%b%b ceb=%b want rdy=%b%b ceb=%b", cyc, m0_ready, m1_ready, sram_ceb, e0, e1, e_ceb);
      end
      if (m0_valid && e1) streak = (streak < SM) ? streak + 1 : SM;
      else streak = 0;
      p0 = e0; p1 = e1; p1_rd = e1 && !m1_we;
      if (e0) p0_d = ref_mem[m0_addr[5:0]];
      if (e1) begin
        if (m1_we) begin
          w = ref_mem[m1_addr[5:0]];
          for (int b = 0; b < 4; b++) if (m1_wstrb[b]) w[8*b +: 8] = m1_wdata[8*b +: 8];
          ref_mem[m1_addr[5:0]] = w;
        end else begin
          p1_d = ref_mem[m1_addr[5:0]];
        end
      end
      next_cycle();
      if (e0 || !m0_valid) begin
        a = $urandom_range(0, 63);
        m0_valid = ($urandom_range(0, 3) != 0);
        m0_addr  = AW'(a);
      end
      if (e1 || !m1_valid) begin
        a = $urandom_range(0, 63);
        m1_valid = ($urandom_range(0, 3) != 0);
        m1_we    = $urandom_range(0, 1) != 0;
        m1_wstrb = 4'($urandom);
        m1_addr  = AW'(a);
        m1_wdata = $urandom;
      end
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      mem[i]     = ref_mem[i];
    end
    next_cycle();
    test_reset();
    test_m0_stream();
    test_partial_write();
    test_contention();
    test_zero_strobe();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
